// File: rtl/bus_pkg.sv
// Shared types and defaults for the serial system bus front end.
package bus_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;
  localparam int DEV_W_DEF  = 4;
  localparam int ACK_TO_DEF = 16;
  localparam int CNT_W      = 16;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam logic [1:0] SLV_NONE = 2'd0;
  localparam logic [1:0] SLV_1    = 2'd1;
  localparam logic [1:0] SLV_2    = 2'd2;
  localparam logic [1:0] SLV_3    = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REQ,
    ST_DEV,
    ST_WAIT_ACK,
    ST_ADDR,
    ST_WDATA,
    ST_RWAIT,
    ST_RDATA,
    ST_DONE
  } mst_state_e;

endpackage

// File: rtl/bus_arbiter.sv
// Two-requester non-preemptive bus arbiter; requester 1 wins ties from idle.
module bus_arbiter
  import bus_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic breq1,
  input  logic breq2,
  output logic bgrant1,
  output logic bgrant2,
  output logic msel
);

  // A released grant leaves the bus idle for one edge before re-granting.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bgrant1 <= 1'b0;
      bgrant2 <= 1'b0;
      msel    <= 1'b0;
    end else if (bgrant1) begin
      if (!breq1) bgrant1 <= 1'b0;
    end else if (bgrant2) begin
      if (!breq2) bgrant2 <= 1'b0;
    end else if (breq1) begin
      bgrant1 <= 1'b1;
      msel    <= 1'b0;
    end else if (breq2) begin
      bgrant2 <= 1'b1;
      msel    <= 1'b1;
    end
  end

endmodule

// File: rtl/bus_master_frontend.sv
// Parallel-to-serial bus master with arbiter and slave decoder.
// Optional MASTER_ACK_TIMEOUT_EN aborts a transaction whose ack never arrives.
module bus_master_frontend
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH        = ADDR_W_DEF,
  parameter int DATA_WIDTH        = DATA_W_DEF,
  parameter int DEVICE_ADDR_WIDTH = DEV_W_DEF,
  parameter int ACK_TIMEOUT       = ACK_TO_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] dwdata,
  output logic [DATA_WIDTH-1:0] drdata,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic                  dvalid,
  output logic                  dready,
  input  logic                  dmode,
  input  logic                  mrdata,
  input  logic                  svalid,
  output logic                  mwdata,
  output logic                  mmode,
  output logic                  mvalid,
  input  logic                  breq2,
  output logic                  bgrant2,
  output logic                  msel,
  output logic                  mvalid1,
  output logic                  mvalid2,
  output logic                  mvalid3,
  output logic                  ssel,
  output logic                  ack
);

`ifdef MASTER_ACK_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam int TX_W    = ADDR_WIDTH + DATA_WIDTH;
  localparam int LADDR_W = ADDR_WIDTH - DEVICE_ADDR_WIDTH;
  localparam int DCNT_W  = $clog2(DEVICE_ADDR_WIDTH + 1);

  mst_state_e            state, state_nxt;
  logic [TX_W-1:0]       tx_sh;
  logic [DATA_WIDTH-2:0] rx_sh;
  logic [DATA_WIDTH-1:0] rx_word;
  logic [CNT_W-1:0]      cnt;
  logic                  mbreq, bgrant1, step, rx_bit, rx_last;
  logic [DCNT_W-1:0]     dcnt;
  logic                  dev_prev, own_grant;
  logic [1:0]            slv, dev_idx;

  bus_arbiter u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .breq1   (mbreq),
    .breq2   (breq2),
    .bgrant1 (bgrant1),
    .bgrant2 (bgrant2),
    .msel    (msel)
  );

  assign dready  = (state == ST_IDLE);
  assign mvalid  = (state == ST_DEV) || (state == ST_ADDR) || (state == ST_WDATA);
  assign mwdata  = mvalid & tx_sh[TX_W-1];
  assign mbreq   = !((state == ST_IDLE) || (state == ST_DONE));
  assign rx_bit  = svalid && ((state == ST_RWAIT) || (state == ST_RDATA));
  assign rx_last = svalid && (state == ST_RDATA) && (cnt == CNT_W'(DATA_WIDTH-1));
  assign rx_word = {rx_sh, mrdata};
  // cnt counts bits (or wait cycles) within the current phase.
  assign step    = mvalid || (state == ST_WAIT_ACK) || ((state == ST_RDATA) && svalid);

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (dvalid) state_nxt = ST_REQ;
      ST_REQ:      if (bgrant1) state_nxt = ST_DEV;
      ST_DEV:      if (cnt == CNT_W'(DEVICE_ADDR_WIDTH-1)) state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK: if (ack) state_nxt = ST_ADDR;
                   else if (TMO_EN && (cnt == CNT_W'(ACK_TIMEOUT-1))) state_nxt = ST_DONE;
      ST_ADDR:     if (cnt == CNT_W'(LADDR_W-1))
                     state_nxt = (mmode == MODE_WRITE) ? ST_WDATA : ST_RWAIT;
      ST_WDATA:    if (cnt == CNT_W'(DATA_WIDTH-1)) state_nxt = ST_DONE;
      ST_RWAIT:    if (svalid) state_nxt = ST_RDATA;
      ST_RDATA:    if (rx_last) state_nxt = ST_DONE;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_sh  <= '0;
      rx_sh  <= '0;
      cnt    <= '0;
      mmode  <= MODE_READ;
      drdata <= '0;
    end else begin
      if (dready && dvalid) begin
        tx_sh <= {daddr, dwdata};
        mmode <= dmode;
      end else if (mvalid) begin
        tx_sh <= tx_sh << 1;
      end
      // The first read bit is taken in RWAIT, so RDATA starts at one.
      if (state_nxt != state) cnt <= (state == ST_RWAIT) ? CNT_W'(1) : '0;
      else if (step)          cnt <= cnt + 1'b1;
      if (rx_bit)  rx_sh  <= rx_word[DATA_WIDTH-2:0];
      if (rx_last) drdata <= rx_word;
    end
  end

  // Only the last two device bits pick the slave, so only those are kept.
  assign dev_idx   = {dev_prev, mwdata};
  assign own_grant = msel ? bgrant2 : bgrant1;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      dcnt     <= '0;
      dev_prev <= 1'b0;
      slv      <= SLV_NONE;
      ssel     <= 1'b0;
      ack      <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (!own_grant) begin
        dcnt <= '0;
        slv  <= SLV_NONE;
        ssel <= 1'b0;
      end else if (mvalid && !ssel && (dcnt < DCNT_W'(DEVICE_ADDR_WIDTH))) begin
        dev_prev <= mwdata;
        dcnt     <= dcnt + 1'b1;
        if ((dcnt == DCNT_W'(DEVICE_ADDR_WIDTH-1)) && (dev_idx != SLV_NONE)) begin
          ack  <= 1'b1;
          ssel <= 1'b1;
          slv  <= dev_idx;
        end
      end
    end
  end

  assign mvalid1 = mvalid & ssel & (slv == SLV_1);
  assign mvalid2 = mvalid & ssel & (slv == SLV_2);
  assign mvalid3 = mvalid & ssel & (slv == SLV_3);

endmodule

// File: tb/tb_bus_master_frontend.sv
// Scoreboard bench for bus_master_frontend: serial bits and read data are queued at issue.
module tb_bus_master_frontend;

  localparam int AW = 16, DW = 8, DEVW = 4;

  logic clk = 1'b0, rstn = 1'b0;
  logic [DW-1:0] dwdata = '0, drdata;
  logic [AW-1:0] daddr = '0;
  logic dvalid = 0, dready, dmode = 0, mrdata = 0, svalid = 0;
  logic mwdata, mmode, mvalid, breq2 = 0, bgrant2, msel;
  logic mvalid1, mvalid2, mvalid3, ssel, ack;

  always #5 clk = ~clk;

  bus_master_frontend #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEVICE_ADDR_WIDTH(DEVW), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn), .dwdata(dwdata), .drdata(drdata), .daddr(daddr),
    .dvalid(dvalid), .dready(dready), .dmode(dmode), .mrdata(mrdata), .svalid(svalid),
    .mwdata(mwdata), .mmode(mmode), .mvalid(mvalid), .breq2(breq2), .bgrant2(bgrant2),
    .msel(msel), .mvalid1(mvalid1), .mvalid2(mvalid2), .mvalid3(mvalid3), .ssel(ssel), .ack(ack)
  );

  int checks = 0, fails = 0;
  logic bit_q[$];
  logic [DW-1:0] rd_q[$];
  logic mon_b;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  // Every valid serial bit must match the next expected one.
  always @(negedge clk) begin
    if (rstn && mvalid) begin
      if (bit_q.size() == 0) chk("mbit_extra", 32'd1, 32'd0);
      else begin
        mon_b = bit_q.pop_front();
        chk("mbit", {31'd0, mwdata}, {31'd0, mon_b});
      end
    end
  end

  task automatic start_txn(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic m, input int nb);
    logic [AW+DW-1:0] v;
    v = {a, d};
    daddr = a; dwdata = d; dmode = m; dvalid = 1'b1;
    for (int i = 0; i < nb; i++) bit_q.push_back(v[AW+DW-1-i]);
    @(negedge clk);
    dvalid = 1'b0;
  endtask

  task automatic finish_txn(input int n0, input int exp_low, input int exp_ack, input int slave,
                            input logic [DW-1:0] rpat, input bit rd, input int gap_n);
    int n, ack_n, ri;
    logic [2:0] seen;
    n = n0; ack_n = -1; ri = 0; seen = '0;
    while (!dready && n < 300) begin
      if (ack && ack_n < 0) ack_n = n;
      seen |= {mvalid3, mvalid2, mvalid1};
      if (rd && n >= 20 && n != gap_n && ri < DW) begin
        svalid = 1'b1; mrdata = rpat[DW-1-ri]; ri++;
      end else svalid = 1'b0;
      @(negedge clk); n++;
    end
    svalid = 1'b0;
    chk("done_in_time", {31'd0, dready}, 32'd1);
    if (exp_low >= 0) chk("dready_low", n - 1, exp_low);
    if (exp_ack >= 0) chk("ack_at", ack_n, exp_ack);
    chk("route", {29'd0, seen}, 32'd1 << (slave - 1));
    chk("bits_left", bit_q.size(), 0);
    if (rd) begin
      if (rd_q.size() == 0) chk("rd_q_empty", 32'd1, 32'd0);
      else chk("drdata", {24'd0, drdata}, {24'd0, rd_q.pop_front()});
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk(tag, {dready, mvalid, mwdata, mmode, ack, ssel, bgrant2, msel, mvalid1, mvalid2, mvalid3},
        11'b100_0000_0000);
    chk("rst_drdata", {24'd0, drdata}, 32'd0);
    chk("rst_grant1", {31'd0, dut.bgrant1}, 32'd0);
  endtask

  initial begin
    int ack_seen, ssel_seen;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset_outs");
    rstn = 1'b1;
    @(negedge clk);

    // Write 0x9234/0xAA to slave 1.
    start_txn(16'h9234, 8'hAA, 1'b1, AW + DW);
    chk("mmode_w", {31'd0, mmode}, 32'd1);
    finish_txn(1, 28, 7, 1, '0, 1'b0, 0);

    // Read 0x2010 from slave 2 with one svalid gap.
    start_txn(16'h2010, 8'h00, 1'b0, AW);
    rd_q.push_back(8'h5C);
    finish_txn(1, 29, 7, 2, 8'h5C, 1'b1, 23);

    // External master holds the bus before a local write.
    breq2 = 1'b1;
    @(negedge clk);
    chk("ext_grant", {30'd0, bgrant2, msel}, 32'b11);
    start_txn(16'h9234, 8'h55, 1'b1, AW + DW);
    repeat (3) @(negedge clk);
    chk("local_waits", {30'd0, dut.bgrant1, dready}, 32'b00);
    breq2 = 1'b0;
    @(negedge clk);
    chk("idle_gap", {30'd0, dut.bgrant1, bgrant2}, 32'b00);
    @(negedge clk);
    chk("local_grant", {30'd0, dut.bgrant1, msel}, 32'b10);
    finish_txn(1, -1, -1, 1, '0, 1'b0, 0);

    // Both request together from idle: internal wins; external follows.
    start_txn(16'h3ABC, 8'h0F, 1'b1, AW + DW);
    breq2 = 1'b1;
    @(negedge clk);
    chk("tie_grant", {29'd0, dut.bgrant1, bgrant2, msel}, 32'b100);
    finish_txn(2, 28, 7, 3, '0, 1'b0, 0);
    @(negedge clk);
    chk("handover", {30'd0, bgrant2, msel}, 32'b11);
    breq2 = 1'b0;
    repeat (2) @(negedge clk);

    // Read once more so drdata is nonzero, then reset during ADDR.
    start_txn(16'h2010, 8'h00, 1'b0, AW);
    rd_q.push_back(8'hC3);
    finish_txn(1, 28, 7, 2, 8'hC3, 1'b1, 0);
    start_txn(16'h9234, 8'hAA, 1'b1, AW + DW);
    repeat (9) @(negedge clk);
    chk("addr_phase", {30'd0, mvalid, ssel}, 32'b11);
    rstn = 1'b0;
    bit_q.delete();
    @(negedge clk);
    chk_reset_outs("midreset_outs");
    rstn = 1'b1;
    @(negedge clk);
    start_txn(16'h9234, 8'hAA, 1'b1, AW + DW);
    finish_txn(1, 28, 7, 1, '0, 1'b0, 0);

    // Device field 0x4 selects no slave: no ack, master parks in WAIT_ACK.
    start_txn(16'h4123, 8'h77, 1'b1, DEVW);
    ack_seen = 0; ssel_seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (ack) ack_seen++;
      if (ssel) ssel_seen++;
    end
    chk("inv_ack", ack_seen, 0);
    chk("inv_ssel", ssel_seen, 0);
    chk("inv_hold", {31'd0, dready}, 32'd0);
    chk("inv_bits", bit_q.size(), 0);
    rstn = 1'b0;
    @(negedge clk);
    chk("inv_reset", {31'd0, dready}, 32'd1);
    rstn = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
